// File: rtl/mat_operand_loader.sv
// mat_operand_loader
//   Upstream feeder for the matrix accelerator. Packs 32-bit operand words
//   from a valid/ready stream into the mat_A and mat_B element arrays, then
//   pulses start for RUN_CYCLES cycles, waits for the accelerator's done and
//   raises a one-cycle irq.
//
//   Optional feature macro: MAT_LOADER_TIMEOUT_EN
//     defined   : WAIT is bounded by TIMEOUT_CYCLES; expiry sets the sticky err
//                 flag and still finishes through FIN so irq pulses.
//     undefined : WAIT lasts until done; err is tied to 0.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   clr               synchronous abort back to IDLE (matrices retained)
//   go                one-cycle arm pulse, honoured only in IDLE
//   in_valid/in_ready operand word handshake
//   in_data[31:0]     four packed elements, byte k is element k
//   mat_A, mat_B      operand arrays to the accelerator
//   start             accelerator start, high for RUN_CYCLES cycles
//   done              accelerator completion, sampled only in WAIT
//   busy              high in every state except IDLE
//   irq               one-cycle completion pulse
//   err               sticky timeout flag
//
// State | meaning
// ------+-------------------------------------------------
// IDLE  | waiting for go
// LOAD_A| accepting words into mat_A
// LOAD_B| accepting words into mat_B
// RUN   | start held high, run counter counting down
// WAIT  | waiting for done (optionally bounded)
// FIN   | irq pulse, back to IDLE next cycle
module mat_operand_loader #(
  parameter int MAT_BYTES      = 1024,
  parameter int DAT_SIZE       = 8,
  parameter int RUN_CYCLES     = 1,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clr,
  input  logic                               go,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [31:0]                        in_data,
  output logic [MAT_BYTES-1:0][DAT_SIZE-1:0] mat_A,
  output logic [MAT_BYTES-1:0][DAT_SIZE-1:0] mat_B,
  output logic                               start,
  input  logic                               done,
  output logic                               busy,
  output logic                               irq,
  output logic                               err
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD_A = 3'd1;
  localparam logic [2:0] LOAD_B = 3'd2;
  localparam logic [2:0] RUN    = 3'd3;
  localparam logic [2:0] WAIT   = 3'd4;
  localparam logic [2:0] FIN    = 3'd5;

  localparam int WORDS = MAT_BYTES / 4;
  localparam int WCW   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [WCW-1:0] LAST_WORD = WCW'(WORDS - 1);
  // Run counter counts down from RUN_CYCLES-1; terminal count 0 ends RUN.
  localparam logic [7:0] RUN_LOAD = 8'(RUN_CYCLES - 1);

  if (RUN_CYCLES < 1 || RUN_CYCLES > 255 || TIMEOUT_CYCLES < 1 ||
      (MAT_BYTES % 4) != 0 || MAT_BYTES < 8) begin : g_bad_param
    $error("mat_operand_loader: illegal parameter combination");
  end

  logic [2:0]     state;
  logic [WCW-1:0] word_cnt;
  logic [7:0]     run_cnt;
  logic           timeout_hit;
  logic           accept;

  assign accept = in_valid && ((state == LOAD_A) || (state == LOAD_B));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      word_cnt <= '0;
      run_cnt  <= '0;
    end else if (clr) begin
      state    <= IDLE;
      word_cnt <= '0;
      run_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            state    <= LOAD_A;
            word_cnt <= '0;
          end
        end
        LOAD_A, LOAD_B: begin
          if (in_valid) begin
            if (word_cnt == LAST_WORD) begin
              word_cnt <= '0;
              run_cnt  <= RUN_LOAD;
              state    <= (state == LOAD_A) ? LOAD_B : RUN;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
        RUN: begin
          if (run_cnt == '0) state <= WAIT;
          else               run_cnt <= run_cnt - 1'b1;
        end
        WAIT: begin
          // done wins over a same-cycle timeout expiry
          if (done || timeout_hit) state <= FIN;
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Matrix storage is only written by accepted words, so it holds its value
  // from the end of LOAD_B until the next load, and survives clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mat_A <= '0;
      mat_B <= '0;
    end else if (!clr && accept) begin
      for (int k = 0; k < 4; k++) begin
        if (state == LOAD_A) mat_A[{word_cnt, 2'(k)}] <= DAT_SIZE'(in_data[8*k +: 8]);
        else                 mat_B[{word_cnt, 2'(k)}] <= DAT_SIZE'(in_data[8*k +: 8]);
      end
    end
  end

`ifdef MAT_LOADER_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TCW-1:0] wait_cnt;
  logic           err_q;

  // Reloaded on every RUN cycle so WAIT always starts at TIMEOUT_CYCLES-1.
  assign timeout_hit = (wait_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else if (clr) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state == IDLE && go) err_q <= 1'b0;
      if (state == RUN) begin
        wait_cnt <= TCW'(TIMEOUT_CYCLES - 1);
      end else if (state == WAIT && !done) begin
        if (wait_cnt == '0) err_q <= 1'b1;
        else                wait_cnt <= wait_cnt - 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  assign in_ready = (state == LOAD_A) || (state == LOAD_B);
  assign start    = (state == RUN);
  assign busy     = (state != IDLE);
  assign irq      = (state == FIN);

endmodule

// File: tb/tb_mat_operand_loader.sv
// Testbench for mat_operand_loader: scoreboard of expected matrix elements
// pushed as words are driven, popped and compared against mat_A/mat_B.
module tb_mat_operand_loader;
  localparam int MB      = 1024;
  localparam int WORDS   = MB / 4;
  localparam int RUN_CYC = 3;
  localparam int TO_CYC  = 16;

  logic clk = 1'b0, rst = 1'b1, clr = 1'b0, go = 1'b0, in_valid = 1'b0, done = 1'b0;
  logic [31:0] in_data = '0;
  logic in_ready, start, busy, irq, err;
  logic [MB-1:0][7:0] mat_A, mat_B;

  int checks = 0;
  int errors = 0;
  int irq_count = 0;

  typedef struct {
    bit         sel;
    logic [9:0] idx;
    logic [7:0] val;
  } sb_t;
  sb_t sb_q[$];
  logic [7:0] exp_a [MB];
  logic [7:0] exp_b [MB];

  mat_operand_loader #(
    .MAT_BYTES(MB), .DAT_SIZE(8), .RUN_CYCLES(RUN_CYC), .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk(clk), .rst(rst), .clr(clr), .go(go), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .mat_A(mat_A), .mat_B(mat_B),
    .start(start), .done(done), .busy(busy), .irq(irq), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (irq) irq_count <= irq_count + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_go();
    step(); go = 1'b1;
    step(); go = 1'b0;
  endtask

  task automatic pulse_done();
    done = 1'b1;
    step(); done = 1'b0;
  endtask

  task automatic clear_model();
    for (int k = 0; k < MB; k++) begin
      exp_a[k] = 8'h00;
      exp_b[k] = 8'h00;
    end
    sb_q.delete();
  endtask

  // Drive one word (global index w: A for w<WORDS, B otherwise) and push the
  // elements it should produce. Returns at #1 after the accepting edge.
  task automatic send_word(input int w, input logic [31:0] d, output bit ok);
    int   guard;
    sb_t  e;
    guard = 0;
    ok = 1'b1;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && guard < 50) begin
      step();
      guard++;
    end
    if (!in_ready) begin
      ok = 1'b0;
      return;
    end
    step();
    for (int k = 0; k < 4; k++) begin
      e.sel = (w >= WORDS);
      e.idx = 10'(4 * (w % WORDS) + k);
      e.val = d[8*k +: 8];
      sb_q.push_back(e);
      if (e.sel) exp_b[e.idx] = e.val;
      else       exp_a[e.idx] = e.val;
    end
  endtask

  function automatic logic [31:0] pat_word(input int w);
    return {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
  endfunction

  // mode 0: counting pattern; 1: random data, random gaps, stray done in
  // LOAD_B; 2: inverted counting pattern.
  task automatic do_load(input int mode, output bit ok);
    bit ok1;
    int g;
    logic [31:0] d;
    ok = 1'b1;
    for (int w = 0; w < 2 * WORDS; w++) begin
      if (mode == 0)      d = pat_word(w);
      else if (mode == 2) d = ~pat_word(w);
      else                d = $urandom;
      if (mode == 1) begin
        g = $urandom_range(0, 2);
        if (g != 0) begin
          in_valid = 1'b0;
          repeat (g) step();
        end
        if (w == WORDS + 40) begin
          in_valid = 1'b0;
          pulse_done();
        end
      end
      send_word(w, d, ok1);
      if (!ok1) begin
        ok = 1'b0;
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
  endtask

  function automatic int drain_sb(output string info);
    int bad;
    sb_t e;
    logic [7:0] act;
    bad = 0;
    info = "none";
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      act = e.sel ? mat_B[e.idx] : mat_A[e.idx];
      if (act !== e.val) begin
        if (bad == 0) info = $sformatf("sel %0d idx %0d got %h want %h", e.sel, e.idx, act, e.val);
        bad++;
      end
    end
    return bad;
  endfunction

  function automatic int model_bad();
    int bad;
    logic [9:0] ki;
    bad = 0;
    for (int k = 0; k < MB; k++) begin
      ki = 10'(k);
      if (mat_A[ki] !== exp_a[ki]) bad++;
      if (mat_B[ki] !== exp_b[ki]) bad++;
    end
    return bad;
  endfunction

  // Counts cycles with start high, beginning at the current cycle.
  task automatic wait_run(output int hi);
    hi = 0;
    while (start && hi < 300) begin
      hi++;
      step();
    end
  endtask

  task automatic test_reset();
    bit ok;
    int bad;
    string info;
    #12;
    checks++;
    if ({in_ready, start, busy, irq, err} !== 5'b0) begin
      errors++; $display("FAIL reset_outputs got %b want 00000", {in_ready, start, busy, irq, err});
    end
    checks++;
    if (mat_A !== '0 || mat_B !== '0) begin
      errors++; $display("FAIL reset_matrices got nonzero want zero");
    end
    @(negedge clk); rst = 1'b0;
    clear_model();
    pulse_go();
    for (int w = 0; w < 100; w++) begin
      send_word(w, pat_word(w), ok);
      if (!ok) break;
    end
    in_valid = 1'b0;
    bad = drain_sb(info);
    checks++;
    if (!ok || bad != 0) begin
      errors++; $display("FAIL partial_load ok %0d bad %0d first %s want 0 bad", ok, bad, info);
    end
    @(posedge clk); #3 rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, start, busy, irq, err} !== 5'b0) begin
      errors++; $display("FAIL async_reset_outputs got %b want 00000", {in_ready, start, busy, irq, err});
    end
    checks++;
    if (mat_A !== '0) begin
      errors++; $display("FAIL async_reset_mat_A got nonzero want zero");
    end
    clear_model();
    @(negedge clk); rst = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle busy %b want 0", busy);
    end
  endtask

  task automatic test_full_transaction();
    bit ok;
    int bad, hi, c0;
    string info;
    sb_t e;
    logic [7:0] act;
    pulse_go();
    checks++;
    if ({busy, in_ready} !== 2'b11) begin
      errors++; $display("FAIL go_latency busy/in_ready %b want 11", {busy, in_ready});
    end
    bad = 0;
    info = "none";
    ok = 1'b1;
    for (int w = 0; w < 2 * WORDS; w++) begin
      send_word(w, pat_word(w), ok);
      if (!ok) break;
      // elements of the word just accepted must be visible in this cycle
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        act = e.sel ? mat_B[e.idx] : mat_A[e.idx];
        if (act !== e.val) begin
          if (bad == 0) info = $sformatf("sel %0d idx %0d got %h want %h", e.sel, e.idx, act, e.val);
          bad++;
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (!ok || bad != 0) begin
      errors++; $display("FAIL word_visible_next_cycle ok %0d bad %0d first %s", ok, bad, info);
    end
    checks++;
    if ({start, in_ready} !== 2'b10) begin
      errors++; $display("FAIL start_after_last_word start/in_ready %b want 10", {start, in_ready});
    end
    wait_run(hi);
    checks++;
    if (hi != RUN_CYC) begin
      errors++; $display("FAIL start_width got %0d want %0d", hi, RUN_CYC);
    end
    c0 = irq_count;
    repeat (4) step();
    checks++;
    if (irq_count != c0 || busy !== 1'b1) begin
      errors++; $display("FAIL wait_hold irqs %0d busy %b want 0 irqs busy 1", irq_count - c0, busy);
    end
    pulse_done();
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL irq_after_done got %b want 1", irq);
    end
    step();
    checks++;
    if ({irq, busy} !== 2'b00 || irq_count != c0 + 1) begin
      errors++; $display("FAIL fin_to_idle irq/busy %b irqs %0d want 00 and 1 irq", {irq, busy}, irq_count - c0);
    end
    bad = 0;
    for (int k = 0; k < MB; k++) begin
      if (mat_A[10'(k)] !== 8'(k) || mat_B[10'(k)] !== 8'(k)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL full_contents bad %0d want 0", bad);
    end
  endtask

  task automatic test_stalls_early_done();
    bit ok;
    int bad, hi, c0;
    string info;
    c0 = irq_count;
    pulse_go();
    do_load(1, ok);
    bad = drain_sb(info);
    checks++;
    if (!ok || bad != 0) begin
      errors++; $display("FAIL stalled_load ok %0d bad %0d first %s", ok, bad, info);
    end
    checks++;
    if (irq_count != c0 || start !== 1'b1) begin
      errors++; $display("FAIL stray_done irqs %0d start %b want 0 irqs start 1", irq_count - c0, start);
    end
    wait_run(hi);
    checks++;
    if (hi != RUN_CYC) begin
      errors++; $display("FAIL stall_start_width got %0d want %0d", hi, RUN_CYC);
    end
    repeat (3) step();
    pulse_done();
    step();
    checks++;
    if (irq_count != c0 + 1 || busy !== 1'b0) begin
      errors++; $display("FAIL stall_irq irqs %0d busy %b want 1 irq busy 0", irq_count - c0, busy);
    end
  endtask

  task automatic test_go_in_wait();
    bit ok;
    int hi, c0;
    c0 = irq_count;
    pulse_go();
    do_load(0, ok);
    sb_q.delete();
    wait_run(hi);
    checks++;
    if (!ok || hi != RUN_CYC) begin
      errors++; $display("FAIL multi_start ok %0d width %0d want %0d", ok, hi, RUN_CYC);
    end
    pulse_go();
    step();
    checks++;
    if ({busy, in_ready, start} !== 3'b100 || irq_count != c0) begin
      errors++; $display("FAIL go_in_wait busy/in_ready/start %b irqs %0d want 100", {busy, in_ready, start}, irq_count - c0);
    end
    pulse_done();
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL go_in_wait_irq got %b want 1", irq);
    end
    step();
  endtask

  task automatic test_abort();
    bit ok;
    int hi, c0, bad;
    string info;
    pulse_go();
    do_load(2, ok);
    sb_q.delete();
    wait_run(hi);
    repeat (2) step();
    c0 = irq_count;
    clr = 1'b1;
    step(); clr = 1'b0;
    checks++;
    if ({busy, irq, start, in_ready} !== 4'b0000) begin
      errors++; $display("FAIL clr_to_idle busy/irq/start/in_ready %b want 0000", {busy, irq, start, in_ready});
    end
    pulse_done();
    repeat (3) step();
    checks++;
    if (irq_count != c0 || busy !== 1'b0) begin
      errors++; $display("FAIL clr_no_irq irqs %0d busy %b want 0 irqs busy 0", irq_count - c0, busy);
    end
    bad = model_bad();
    checks++;
    if (!ok || bad != 0) begin
      errors++; $display("FAIL clr_retains ok %0d bad %0d want 0", ok, bad);
    end
    pulse_go();
    do_load(0, ok);
    bad = drain_sb(info);
    checks++;
    if (!ok || bad != 0) begin
      errors++; $display("FAIL reload ok %0d bad %0d first %s", ok, bad, info);
    end
    wait_run(hi);
    pulse_done();
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL reload_irq got %b want 1", irq);
    end
    step();
  endtask

`ifdef MAT_LOADER_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int hi, early;
    pulse_go();
    do_load(0, ok);
    sb_q.delete();
    wait_run(hi);
    early = 0;
    if (irq !== 1'b0) early++;
    for (int i = 2; i <= TO_CYC; i++) begin
      step();
      if (irq !== 1'b0) early++;
    end
    checks++;
    if (!ok || early != 0) begin
      errors++; $display("FAIL timeout_early ok %0d early irq cycles %0d want 0", ok, early);
    end
    step();
    checks++;
    if ({irq, err} !== 2'b11) begin
      errors++; $display("FAIL timeout_expiry irq/err %b want 11", {irq, err});
    end
    step();
    checks++;
    if ({busy, err} !== 2'b01) begin
      errors++; $display("FAIL err_sticky busy/err %b want 01", {busy, err});
    end
    pulse_go();
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL err_clear_on_go got %b want 0", err);
    end
    do_load(0, ok);
    sb_q.delete();
    wait_run(hi);
    repeat (TO_CYC - 1) step();
    pulse_done();
    checks++;
    if ({irq, err} !== 2'b10) begin
      errors++; $display("FAIL done_on_expiry irq/err %b want 10", {irq, err});
    end
    step();
  endtask
`else
  task automatic test_no_timeout();
    bit ok;
    int hi, c0;
    pulse_go();
    do_load(0, ok);
    sb_q.delete();
    wait_run(hi);
    c0 = irq_count;
    repeat (40) step();
    checks++;
    if (!ok || {busy, err} !== 2'b10 || irq_count != c0) begin
      errors++; $display("FAIL unbounded_wait ok %0d busy/err %b irqs %0d want 10 and 0 irqs", ok, {busy, err}, irq_count - c0);
    end
    pulse_done();
    checks++;
    if ({irq, err} !== 2'b10) begin
      errors++; $display("FAIL unbounded_done irq/err %b want 10", {irq, err});
    end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_full_transaction();
    test_stalls_early_done();
    test_go_in_wait();
    test_abort();
`ifdef MAT_LOADER_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
